// File: rtl/prt_dp_pm_pkg.sv
// Shared types for the policy-maker program ROM path.
// Holds the loader FSM states, word geometry and partial-word packing.
package prt_dp_pm_pkg;

    localparam int LP_WORD_W = 32;
    localparam int LP_LANES  = 4;
    localparam int LP_LANE_W = $clog2(LP_LANES);
    localparam int LP_BUF_W  = LP_WORD_W - 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE,
        ST_ERR
    } ldr_st_e;

    // Keep only the first n filled lanes; upper lanes read as zero.
    function automatic logic [LP_WORD_W-1:0] f_partial(
        input logic [LP_BUF_W-1:0]  b,
        input logic [LP_LANE_W-1:0] n
    );
        logic [LP_WORD_W-1:0] w;
        w = '0;
        case (n)
            2'd1:    w = {24'h0, b[7:0]};
            2'd2:    w = {16'h0, b[15:0]};
            2'd3:    w = {8'h0, b[23:0]};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/prt_dp_pm_rom_ldr.sv
// Host image loader for the policy-maker program ROM.
// Packs bytes little-endian into 32-bit words and drives the ROM init port.
//
// Ports:
//   CLK_IN, RST_IN           clock, async active-high reset
//   LDR_STR/DAT/VLD/END_IN   host byte stream with start/end pulses
//   INIT_STR/DAT/VLD_OUT     ROM pointer clear, word, write strobe
//   PM_HOLD_OUT              holds the policy maker in reset while loading
//   STA_DONE/ERR/WRDS_OUT    load status for the host register block
module prt_dp_pm_rom_ldr
    import prt_dp_pm_pkg::*;
#(
    parameter int P_ADR = 10
) (
    input  logic                 CLK_IN,
    input  logic                 RST_IN,
    input  logic                 LDR_STR_IN,
    input  logic [7:0]           LDR_DAT_IN,
    input  logic                 LDR_VLD_IN,
    input  logic                 LDR_END_IN,
    output logic                 INIT_STR_OUT,
    output logic [31:0]          INIT_DAT_OUT,
    output logic                 INIT_VLD_OUT,
    output logic                 PM_HOLD_OUT,
    output logic                 STA_DONE_OUT,
    output logic                 STA_ERR_OUT,
    output logic [P_ADR:0]       STA_WRDS_OUT
);

    // Word count at which the ROM is full: 2**P_ADR.
    localparam logic [P_ADR:0]     LP_FULL = {1'b1, {P_ADR{1'b0}}};
    localparam logic [LP_LANE_W-1:0] LP_LAST = LP_LANE_W'(LP_LANES - 1);

    ldr_st_e                  state_q;
    logic [LP_LANE_W-1:0]     lane_q;
    logic [LP_BUF_W-1:0]      buf_q;
    logic [P_ADR:0]           wrds_q;
    logic                     str_q;
    logic [LP_WORD_W-1:0]     dat_q;
    logic                     vld_q;
    logic                     hold_q;
    logic                     done_q;
    logic                     err_q;

    logic [LP_LANE_W-1:0]     lane_d;
    logic [LP_BUF_W-1:0]      buf_d;
    logic [LP_WORD_W-1:0]     word_d;
    logic [LP_WORD_W-1:0]     part_d;
    logic                     lane_last;
    logic                     full;

    // Lane bookkeeping including the byte of this cycle, so an END that
    // arrives with a byte sees the updated lane and buffer.
    always_comb begin
        lane_last = (lane_q == LP_LAST);
        full      = (wrds_q == LP_FULL);
        lane_d    = lane_q;
        buf_d     = buf_q;
        if (LDR_VLD_IN) begin
            lane_d = lane_q + 1'b1;
            case (lane_q)
                2'd0:    buf_d[7:0]   = LDR_DAT_IN;
                2'd1:    buf_d[15:8]  = LDR_DAT_IN;
                2'd2:    buf_d[23:16] = LDR_DAT_IN;
                default: buf_d        = buf_q;
            endcase
        end
        word_d = {LDR_DAT_IN, buf_q};
        part_d = f_partial(buf_d, lane_d);
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            buf_q   <= '0;
            wrds_q  <= '0;
            str_q   <= 1'b0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            str_q <= 1'b0;
            vld_q <= 1'b0;
            if (LDR_STR_IN) begin
                // Start overrides any byte or END in the same cycle.
                state_q <= ST_LOAD;
                str_q   <= 1'b1;
                lane_q  <= '0;
                buf_q   <= '0;
                wrds_q  <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                hold_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_LOAD: begin
                        if (LDR_VLD_IN) begin
                            lane_q <= lane_d;
                            buf_q  <= buf_d;
                        end
                        if (LDR_VLD_IN && lane_last) begin
                            if (full) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                dat_q  <= word_d;
                                vld_q  <= 1'b1;
                                wrds_q <= wrds_q + 1'b1;
                                if (LDR_END_IN) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                    hold_q  <= 1'b0;
                                end
                            end
                        end else if (LDR_END_IN) begin
                            if (lane_d == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                hold_q  <= 1'b0;
                            end else if (full) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                // Partial word goes out now; FLUSH
                                // is the one-cycle gap before DONE.
                                dat_q   <= part_d;
                                vld_q   <= 1'b1;
                                wrds_q  <= wrds_q + 1'b1;
                                state_q <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign INIT_STR_OUT = str_q;
    assign INIT_DAT_OUT = dat_q;
    assign INIT_VLD_OUT = vld_q;
    assign PM_HOLD_OUT  = hold_q;
    assign STA_DONE_OUT = done_q;
    assign STA_ERR_OUT  = err_q;
    assign STA_WRDS_OUT = wrds_q;

endmodule

// File: tb/tb_prt_dp_pm_rom_ldr.sv
// Bench for prt_dp_pm_rom_ldr: vector table on a full-size instance,
// hand sequences for overflow (P_ADR=2) and asynchronous reset.
module tb_prt_dp_pm_rom_ldr;

    logic        clk;
    logic        rst;
    logic        str;
    logic [7:0]  dat;
    logic        vld;
    logic        ldr_end;

    logic        o_str, o_vld, o_hold, o_done, o_err;
    logic [31:0] o_dat;
    logic [10:0] o_wrds;

    logic        s_str, s_vld, s_hold, s_done, s_err;
    logic [31:0] s_dat;
    logic [2:0]  s_wrds;

    int checks;
    int failures;

    prt_dp_pm_rom_ldr #(.P_ADR(10)) u_big (
        .CLK_IN       (clk),
        .RST_IN       (rst),
        .LDR_STR_IN   (str),
        .LDR_DAT_IN   (dat),
        .LDR_VLD_IN   (vld),
        .LDR_END_IN   (ldr_end),
        .INIT_STR_OUT (o_str),
        .INIT_DAT_OUT (o_dat),
        .INIT_VLD_OUT (o_vld),
        .PM_HOLD_OUT  (o_hold),
        .STA_DONE_OUT (o_done),
        .STA_ERR_OUT  (o_err),
        .STA_WRDS_OUT (o_wrds)
    );

    prt_dp_pm_rom_ldr #(.P_ADR(2)) u_small (
        .CLK_IN       (clk),
        .RST_IN       (rst),
        .LDR_STR_IN   (str),
        .LDR_DAT_IN   (dat),
        .LDR_VLD_IN   (vld),
        .LDR_END_IN   (ldr_end),
        .INIT_STR_OUT (s_str),
        .INIT_DAT_OUT (s_dat),
        .INIT_VLD_OUT (s_vld),
        .PM_HOLD_OUT  (s_hold),
        .STA_DONE_OUT (s_done),
        .STA_ERR_OUT  (s_err),
        .STA_WRDS_OUT (s_wrds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        str;
        logic        vld;
        logic [7:0]  dat;
        logic        fin;
        logic        e_str;
        logic        e_vld;
        logic [31:0] e_dat;
        logic        e_hold;
        logic        e_done;
        logic        e_err;
        logic [10:0] e_wrds;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] d,
                         input logic f);
        str = s;
        vld = v;
        dat = d;
        ldr_end = f;
    endtask

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic f, input logic es, input logic ev,
                       input logic [31:0] ed, input logic eh,
                       input logic edn, input logic [10:0] ew);
        vec_t x;
        x.str = s; x.vld = v; x.dat = d; x.fin = f;
        x.e_str = es; x.e_vld = ev; x.e_dat = ed; x.e_hold = eh;
        x.e_done = edn; x.e_err = 1'b0; x.e_wrds = ew;
        vt.push_back(x);
    endtask

    int nvld;
    logic [31:0] last_w;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive(0, 0, 8'h00, 0);

        //   str vld dat    end | str vld dat           hold done wrds
        add(0, 1, 8'h5A, 0,   0, 0, 32'h0,          0, 0, 0);
        add(0, 0, 8'h00, 1,   0, 0, 32'h0,          0, 0, 0);
        add(1, 0, 8'h00, 0,   1, 0, 32'h0,          1, 0, 0);
        add(0, 1, 8'h11, 0,   0, 0, 32'h0,          1, 0, 0);
        add(0, 1, 8'h22, 0,   0, 0, 32'h0,          1, 0, 0);
        add(0, 1, 8'h33, 0,   0, 0, 32'h0,          1, 0, 0);
        add(0, 1, 8'h44, 0,   0, 1, 32'h44332211,   1, 0, 1);
        add(0, 1, 8'h55, 0,   0, 0, 32'h44332211,   1, 0, 1);
        add(0, 1, 8'h66, 0,   0, 0, 32'h44332211,   1, 0, 1);
        add(0, 1, 8'h77, 0,   0, 0, 32'h44332211,   1, 0, 1);
        add(0, 1, 8'h88, 0,   0, 1, 32'h88776655,   1, 0, 2);
        add(0, 0, 8'h00, 1,   0, 0, 32'h88776655,   0, 1, 2);
        add(0, 1, 8'h99, 0,   0, 0, 32'h88776655,   0, 1, 2);
        // partial image: flush word one cycle after END, DONE after
        add(1, 0, 8'h00, 0,   1, 0, 32'h88776655,   1, 0, 0);
        add(0, 1, 8'hAA, 0,   0, 0, 32'h88776655,   1, 0, 0);
        add(0, 1, 8'hBB, 0,   0, 0, 32'h88776655,   1, 0, 0);
        add(0, 0, 8'h00, 1,   0, 1, 32'h0000BBAA,   1, 0, 1);
        add(0, 0, 8'h00, 0,   0, 0, 32'h0000BBAA,   0, 1, 1);
        // END with the third byte: byte first, then flush
        add(1, 0, 8'h00, 0,   1, 0, 32'h0000BBAA,   1, 0, 0);
        add(0, 1, 8'h01, 0,   0, 0, 32'h0000BBAA,   1, 0, 0);
        add(0, 1, 8'h02, 0,   0, 0, 32'h0000BBAA,   1, 0, 0);
        add(0, 1, 8'h03, 1,   0, 1, 32'h00030201,   1, 0, 1);
        add(0, 0, 8'h00, 0,   0, 0, 32'h00030201,   0, 1, 1);
        // END with the fourth byte: full word and DONE together
        add(1, 0, 8'h00, 0,   1, 0, 32'h00030201,   1, 0, 0);
        add(0, 1, 8'h10, 0,   0, 0, 32'h00030201,   1, 0, 0);
        add(0, 1, 8'h20, 0,   0, 0, 32'h00030201,   1, 0, 0);
        add(0, 1, 8'h30, 0,   0, 0, 32'h00030201,   1, 0, 0);
        add(0, 1, 8'h40, 1,   0, 1, 32'h40302010,   0, 1, 1);
        // STR with END: STR wins
        add(1, 0, 8'h00, 1,   1, 0, 32'h40302010,   1, 0, 0);
        // STR mid-word with a byte: byte dropped, lane reset
        add(0, 1, 8'hC1, 0,   0, 0, 32'h40302010,   1, 0, 0);
        add(0, 1, 8'hC2, 0,   0, 0, 32'h40302010,   1, 0, 0);
        add(0, 1, 8'hC3, 0,   0, 0, 32'h40302010,   1, 0, 0);
        add(1, 1, 8'hC4, 0,   1, 0, 32'h40302010,   1, 0, 0);
        add(0, 1, 8'hD1, 0,   0, 0, 32'h40302010,   1, 0, 0);
        add(0, 1, 8'hD2, 0,   0, 0, 32'h40302010,   1, 0, 0);
        add(0, 1, 8'hD3, 0,   0, 0, 32'h40302010,   1, 0, 0);
        add(0, 1, 8'hD4, 0,   0, 1, 32'hD4D3D2D1,   1, 0, 1);
        add(0, 0, 8'h00, 1,   0, 0, 32'hD4D3D2D1,   0, 1, 1);

        step();
        step();
        chk("rst_str", {31'h0, o_str}, 32'h0);
        chk("rst_dat", o_dat, 32'h0);
        chk("rst_vld", {31'h0, o_vld}, 32'h0);
        chk("rst_hold", {31'h0, o_hold}, 32'h0);
        chk("rst_done", {31'h0, o_done}, 32'h0);
        chk("rst_err", {31'h0, o_err}, 32'h0);
        chk("rst_wrds", {21'h0, o_wrds}, 32'h0);
        rst = 1'b0;
        step();

        foreach (vt[i]) begin
            drive(vt[i].str, vt[i].vld, vt[i].dat, vt[i].fin);
            step();
            chk($sformatf("v%0d_str", i), {31'h0, o_str},
                {31'h0, vt[i].e_str});
            chk($sformatf("v%0d_vld", i), {31'h0, o_vld},
                {31'h0, vt[i].e_vld});
            chk($sformatf("v%0d_dat", i), o_dat, vt[i].e_dat);
            chk($sformatf("v%0d_hold", i), {31'h0, o_hold},
                {31'h0, vt[i].e_hold});
            chk($sformatf("v%0d_done", i), {31'h0, o_done},
                {31'h0, vt[i].e_done});
            chk($sformatf("v%0d_err", i), {31'h0, o_err},
                {31'h0, vt[i].e_err});
            chk($sformatf("v%0d_wrds", i), {21'h0, o_wrds},
                {21'h0, vt[i].e_wrds});
        end

        // Overflow on the 4-word instance: 20 bytes, 5th word suppressed
        drive(1, 0, 8'h00, 0);
        step();
        nvld = 0;
        last_w = 32'h0;
        for (int b = 1; b <= 20; b++) begin
            drive(0, 1, 8'(b), 0);
            step();
            if (s_vld) begin
                nvld++;
                last_w = s_dat;
            end
            if (b == 16)
                chk("ovf_err_b16", {31'h0, s_err}, 32'h0);
        end
        chk("ovf_nwords", 32'(nvld), 32'd4);
        chk("ovf_lastw", last_w, 32'h100F0E0D);
        chk("ovf_wrds", {29'h0, s_wrds}, 32'd4);
        chk("ovf_err", {31'h0, s_err}, 32'h1);
        chk("ovf_hold", {31'h0, s_hold}, 32'h1);
        drive(0, 0, 8'h00, 1);
        step();
        drive(0, 0, 8'h00, 0);
        step();
        chk("ovf_end_err", {31'h0, s_err}, 32'h1);
        chk("ovf_end_done", {31'h0, s_done}, 32'h0);
        chk("ovf_end_hold", {31'h0, s_hold}, 32'h1);
        chk("ovf_end_vld", {31'h0, s_vld}, 32'h0);

        // Asynchronous reset mid-load, then a clean reload
        drive(1, 0, 8'h00, 0);
        step();
        drive(0, 1, 8'hE1, 0);
        step();
        drive(0, 1, 8'hE2, 0);
        step();
        drive(0, 1, 8'hE3, 0);
        step();
        drive(0, 1, 8'hE4, 0);
        step();
        chk("ar_pre_hold", {31'h0, o_hold}, 32'h1);
        chk("ar_pre_vld", {31'h0, o_vld}, 32'h1);
        drive(0, 0, 8'h00, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_hold", {31'h0, o_hold}, 32'h0);
        chk("ar_vld", {31'h0, o_vld}, 32'h0);
        chk("ar_dat", o_dat, 32'h0);
        chk("ar_wrds", {21'h0, o_wrds}, 32'h0);
        step();
        rst = 1'b0;
        drive(1, 0, 8'h00, 0);
        step();
        chk("rl_str", {31'h0, o_str}, 32'h1);
        for (int b = 0; b < 4; b++) begin
            drive(0, 1, 8'(8'hF0 + b), 0);
            step();
        end
        chk("rl_vld", {31'h0, o_vld}, 32'h1);
        chk("rl_dat", o_dat, 32'hF3F2F1F0);
        chk("rl_wrds", {21'h0, o_wrds}, 32'h1);
        drive(0, 0, 8'h00, 1);
        step();
        drive(0, 0, 8'h00, 0);
        chk("rl_done", {31'h0, o_done}, 32'h1);
        chk("rl_hold", {31'h0, o_hold}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prt_dp_pm_rom_ldr.md
# prt_dp_pm_rom_ldr

Upstream loader for the policy-maker program ROM. It takes a host byte stream (firmware image) and packs it little-endian into 32-bit words. It drives the ROM initialization port (start/data/valid) and holds the policy maker in reset while the image is written. It also reports word count, completion and error status to the host register block.

## Interface
Parameters:
- P_ADR, 10, ROM address bits; capacity P_WRDS = 2**P_ADR words

Ports:
- CLK_IN  in  1  clock, shared with the ROM
- RST_IN  in  1  reset, asynchronous, active-high
- LDR_STR_IN  in  1  start of new image, single-cycle pulse
- LDR_DAT_IN  in  8  image byte
- LDR_VLD_IN  in  1  byte valid
- LDR_END_IN  in  1  end of image, single-cycle pulse
- INIT_STR_OUT  out  1  ROM write-pointer clear pulse
- INIT_DAT_OUT  out  32  ROM word
- INIT_VLD_OUT  out  1  ROM word write strobe
- PM_HOLD_OUT  out  1  hold policy maker in reset
- STA_DONE_OUT  out  1  image loaded without error
- STA_ERR_OUT  out  1  overflow error (image larger than ROM)
- STA_WRDS_OUT  out  P_ADR+1  words written in current or last image

## Operation
- States: IDLE, LOAD, FLUSH, DONE, ERR.
- IDLE: the state after reset. LDR_VLD_IN and LDR_END_IN are ignored here.
- LDR_STR_IN in any state has these effects:
  - go to LOAD
  - pulse INIT_STR_OUT
  - clear the byte lane counter, word counter, DONE and ERR
  - set PM_HOLD_OUT
- LOAD: each valid byte goes into lane (0..3); lane 0 maps to bits [7:0].
  - On lane 3, INIT_DAT_OUT gets the assembled word, INIT_VLD_OUT pulses, the word counter increments and the lane wraps to 0.
- Overflow: a word that completes while the word counter equals P_WRDS is not written. The block goes to ERR.
- LDR_END_IN in LOAD:
  - lane = 0: go to DONE.
  - lane ≠ 0: go to FLUSH. FLUSH emits the partial word with the unfilled upper lanes zeroed, following the same overflow rule, then goes to DONE.
- DONE: STA_DONE_OUT = 1, PM_HOLD_OUT = 0.
- ERR: STA_ERR_OUT = 1 and PM_HOLD_OUT stays 1, so the policy maker never runs a truncated image. Only LDR_STR_IN or reset leaves ERR.
- Simultaneous events:
  - STR with VLD: STR wins and the byte is dropped.
  - END with VLD in LOAD: the byte is accepted first, then END is evaluated using the updated lane.
  - STR with END: STR wins.
- Reset mid-load: all outputs return to their reset values and the policy maker is released. The ROM contents are then partial. The host must reload; the block does not track this.

## Timing
- Reset values: INIT_STR_OUT=0, INIT_DAT_OUT=0, INIT_VLD_OUT=0, PM_HOLD_OUT=0, STA_DONE_OUT=0, STA_ERR_OUT=0, STA_WRDS_OUT=0.
- All outputs are registered.
- INIT_STR_OUT and the rise of PM_HOLD_OUT occur 1 cycle after LDR_STR_IN.
- INIT_VLD_OUT occurs 1 cycle after the 4th byte's LDR_VLD_IN. STA_WRDS_OUT updates in the same cycle.
- FLUSH lasts exactly 1 cycle. Its word appears 1 cycle after LDR_END_IN. DONE follows in the next cycle.
- Without flush, DONE (and the fall of PM_HOLD_OUT) occurs 1 cycle after LDR_END_IN.
- Bytes may arrive back-to-back every cycle. No backpressure: the ROM accepts one word per cycle.
- INIT_VLD_OUT is never high in the same cycle as INIT_STR_OUT.

## Structure
- Shared package prt_dp_pm_pkg holds:
  - the state enum typedef (IDLE, LOAD, FLUSH, DONE, ERR)
  - localparam for the word width (32) and lanes per word (4)
- No sub-module. Lane packing, counters and the FSM fit in a single module.
- Instantiated next to prt_dp_pm_rom with INIT_*_OUT wired directly to its INIT_*_IN ports and the same CLK_IN.

## Test plan
- Reset release: all outputs 0, state IDLE; a byte with no prior STR produces no INIT_VLD_OUT.
- STR, then bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 back-to-back, then END:
  - INIT_STR_OUT pulses once
  - words 0x44332211 and 0x88776655 are written
  - STA_WRDS_OUT=2, STA_DONE_OUT=1, PM_HOLD_OUT falls 1 cycle after END
- STR, bytes 0xAA,0xBB, END: FLUSH writes 0x0000BBAA one cycle after END; STA_WRDS_OUT=1, DONE.
- P_ADR=2: STR then 20 bytes, END:
  - 4 words are written; the 5th is suppressed
  - STA_ERR_OUT=1, PM_HOLD_OUT stays 1, END is ignored
- STR asserted mid-word (after 3 bytes) together with a VLD byte:
  - that byte is dropped, lane resets, INIT_STR_OUT pulses
  - the next 4 bytes form word 0
- RST_IN asserted during LOAD: all outputs go to 0 asynchronously in the same cycle; the next STR loads normally.
